// File: rtl/coef_row_packer.sv
// Row-vector transmitter for the JPEG transpose stage: buffers 8x8 coefficient blocks in a
// two-bank ping-pong store and emits one 8-wide row per cycle.
// Define COEF_ROW_PACKER_COL_ORDER_EN to emit columns instead of rows (built-in transpose).
module coef_row_packer #(
  parameter int unsigned QW = 13
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic signed [QW-1:0] i_data,
  input  logic                 i_valid,
  output logic                 i_hold,
  output logic signed [QW-1:0] q [7:0],
  output logic [2:0]           q_cnt,
  output logic                 q_valid,
  input  logic                 q_hold
);

  logic [QW-1:0] mem [2][64];
  logic [1:0]    full, full_d;
  logic          wbank, rbank;
  logic [5:0]    wcnt;
  logic [2:0]    rrow;
  logic          accept, load, wlast, rlast;

  // The write side never targets a full bank, so stalling on full[wbank] alone is enough.
  assign i_hold = full[wbank];
  assign accept = i_valid & ~full[wbank];
  assign load   = full[rbank] & (~q_valid | ~q_hold);
  assign wlast  = accept & (wcnt == 6'd63);
  assign rlast  = load & (rrow == 3'd7);

  // Set and clear always hit different banks, so both may apply on the same edge.
  always_comb begin
    full_d = full;
    if (wlast) full_d[wbank] = 1'b1;
    if (rlast) full_d[rbank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wbank][wcnt] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      wcnt  <= 6'd0;
    end else begin
      full <= full_d;
      if (accept) begin
        wcnt <= wcnt + 6'd1;
        if (wlast) wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rbank   <= 1'b0;
      rrow    <= 3'd0;
      q_cnt   <= 3'd0;
      q_valid <= 1'b0;
      for (int i = 0; i < 8; i++) q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 8; i++) begin
`ifdef COEF_ROW_PACKER_COL_ORDER_EN
        q[i] <= mem[rbank][{3'(i), rrow}];
`else
        q[i] <= mem[rbank][{rrow, 3'(i)}];
`endif
      end
      q_cnt   <= rrow;
      q_valid <= 1'b1;
      rrow    <= rrow + 3'd1;
      if (rlast) rbank <= ~rbank;
    end else if (!q_hold) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coef_row_packer.sv
// Scoreboard bench for coef_row_packer: a block-level model turns accepted coefficients into
// expected rows; a negedge monitor compares them and the handshake flags.
module tb_coef_row_packer;
  localparam int QW = 13;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic signed [QW-1:0] i_data;
  logic                 i_valid;
  logic                 i_hold;
  logic signed [QW-1:0] q [7:0];
  logic [2:0]           q_cnt;
  logic                 q_valid;
  logic                 q_hold;

  coef_row_packer #(.QW(QW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_hold (i_hold),
    .q      (q),
    .q_cnt  (q_cnt),
    .q_valid(q_valid),
    .q_hold (q_hold)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: partial block, expected rows (8 values each), row index, completion edge.
  int acc[$];
  int exp_data[$];
  int exp_cnt[$];
  int exp_done[$];
  int written = 0;
  int popped = 0;
  int edge_n = 0;
  bit live = 1'b0;

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    bit exp_v;
    int loaded;
    exp_v = (exp_cnt.size() > 0) && (exp_done[0] < edge_n);
    if (live) begin
      chk("q_valid", int'(q_valid), int'(exp_v));
      loaded = popped + (exp_v ? 1 : 0);
      chk("i_hold", int'(i_hold), ((written - loaded / 8) >= 2) ? 1 : 0);
      if (exp_v && q_valid) begin
        chk("q_cnt", int'(q_cnt), exp_cnt[0]);
        for (int i = 0; i < 8; i++) chk($sformatf("q[%0d]", i), int'(q[i]), exp_data[i]);
      end
    end
    if (!resetn) begin
      acc.delete(); exp_data.delete(); exp_cnt.delete(); exp_done.delete();
      written = 0; popped = 0; live = 1'b1;
    end else if (live) begin
      if (exp_v && !q_hold) begin
        for (int i = 0; i < 8; i++) void'(exp_data.pop_front());
        void'(exp_cnt.pop_front());
        void'(exp_done.pop_front());
        popped++;
      end
      if (i_valid && !i_hold) begin
        acc.push_back(int'(i_data));
        if (acc.size() == 64) begin
          for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
`ifdef COEF_ROW_PACKER_COL_ORDER_EN
              exp_data.push_back(acc[8 * i + r]);
`else
              exp_data.push_back(acc[8 * r + i]);
`endif
            end
            exp_cnt.push_back(r);
            exp_done.push_back(edge_n + 1);
          end
          acc.delete();
          written++;
        end
      end
    end
  end

  // Stimulus helpers; inputs change 1 time unit after the rising edge.
  int src[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int max_cycles, output int n_acc);
    bit ok;
    int v;
    n_acc = 0;
    for (int c = 0; c < max_cycles && src.size() > 0; c++) begin
      v = src[0];
      i_valid = 1'b1;
      i_data = v[QW-1:0];
      @(negedge clk);
      ok = !i_hold;
      step();
      if (ok) begin
        void'(src.pop_front());
        n_acc++;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    int n;
    int v;
    bit found;
    resetn = 1'b0; i_valid = 1'b0; i_data = '0; q_hold = 1'b0;
    step(); step();
    resetn = 1'b1;
    chk("rst_q_valid", int'(q_valid), 0);
    chk("rst_i_hold", int'(i_hold), 0);
    chk("rst_q_cnt", int'(q_cnt), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_q[%0d]", i), int'(q[i]), 0);

    // Single ramp block.
    for (int k = 0; k < 64; k++) src.push_back(k);
    drive_src(200, n);
    chk("ramp_accepted", n, 64);
    idle(12);

    // Back-pressure: both banks fill, then drain.
    q_hold = 1'b1;
    for (int k = 0; k < 130; k++) src.push_back(int'($urandom));
    drive_src(140, n);
    chk("bp_accepted", n, 128);
    chk("bp_i_hold", int'(i_hold), 1);
    chk("bp_q_cnt", int'(q_cnt), 0);
    q_hold = 1'b0;
    drive_src(200, n);
    chk("bp_tail_accepted", n, 2);

    // Complete the block and stall on row 3.
    for (int k = 0; k < 62; k++) src.push_back(int'($urandom));
    drive_src(300, n);
    chk("stall_fill_accepted", n, 62);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (q_valid && q_cnt == 3'd3) found = 1'b1;
      else step();
    end
    chk("stall_row3_seen", int'(found), 1);
    q_hold = 1'b1;
    idle(5);
    chk("stall_q_cnt", int'(q_cnt), 3);
    chk("stall_q_valid", int'(q_valid), 1);
    q_hold = 1'b0;
    step();
    chk("after_stall_q_cnt", int'(q_cnt), 4);
    idle(12);

    // Extreme values, sign bit included.
    for (int k = 0; k < 64; k++) src.push_back((k % 2 == 0) ? -(1 << (QW - 1)) : (1 << (QW - 1)) - 1);
    drive_src(200, n);
    chk("extreme_accepted", n, 64);
    idle(12);

    // Random valid / hold traffic.
    for (int c = 0; c < 700; c++) begin
      v = int'($urandom);
      i_data = v[QW-1:0];
      i_valid = ($urandom_range(0, 3) != 0);
      q_hold = ($urandom_range(0, 2) == 0);
      step();
    end
    i_valid = 1'b0; q_hold = 1'b0;
    idle(40);

    // Mid-block reset discards everything buffered.
    for (int k = 0; k < 30; k++) src.push_back(int'($urandom));
    drive_src(100, n);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_q_valid", int'(q_valid), 0);
    chk("mid_rst_i_hold", int'(i_hold), 0);
    chk("mid_rst_q_cnt", int'(q_cnt), 0);
    for (int k = 100; k < 164; k++) src.push_back(k);
    drive_src(200, n);
    chk("post_rst_accepted", n, 64);
    idle(12);
    chk("rows_outstanding", exp_cnt.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
